data_input_top: RTL and testbench

Input staging buffer for the systolic array. It holds BAND_WIDTH independent row banks of SRAM_DEPTH×DATA_WIDTH each, loaded through a single flat write port. On request it streams a burst of BURST_SIZE words out of every bank in parallel, one lane per array row. Lanes are skewed by one cycle per lane index so the data enter the array diagonally.

---
 rtl/data_input_top.sv | 136 +++++++++++++
 tb/tb_data_input_top.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_input_top.sv
// Input staging buffer for the systolic array: BAND_WIDTH row banks loaded
// through one flat write port, read out as a burst on every lane in
// parallel, with lane i delayed by i cycles so data enters diagonally.
module data_input_top #(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 25,
  parameter int DATA_WIDTH = 8,
  localparam int AW = $clog2(SRAM_DEPTH),
  localparam int BA = $clog2(BAND_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic [AW+BA-1:0]      addra,
  input  logic [DATA_WIDTH-1:0] dia,
  input  logic [AW:0]           BURST_SIZE,
  input  logic                  weight_ready_i,
  output logic                  data_valid_o [BAND_WIDTH],
  output logic [DATA_WIDTH-1:0] sa_data_o [BAND_WIDTH],
  output logic                  burst_last_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic [AW:0]           r_n;
  logic [AW:0]           r_cnt;
  logic                  r_en0;
  logic                  r_last0;
  logic [AW-1:0]         r_addr0;
  logic [BAND_WIDTH-1:1] r_en_ch;
  logic [BAND_WIDTH-1:1] r_last_ch;
  logic [AW-1:0]         r_addr_ch [1:BAND_WIDTH-1];
  logic [BAND_WIDTH-1:0] r_rvld;
  logic                  r_rlast;

  logic [BAND_WIDTH-1:0] w_en;
  logic [BAND_WIDTH-1:0] w_last;
  logic [BAND_WIDTH-1:0] w_we;
  logic [AW-1:0]         w_addr [BAND_WIDTH];

  assign w_en   = {r_en_ch, r_en0};
  assign w_last = {r_last_ch, r_last0};

  // Burst control: latch the length, issue lane-0 reads 0..N-1, then wait for the request to drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_en0   <= 1'b0;
      r_last0 <= 1'b0;
      r_addr0 <= '0;
    end else begin
      r_en0   <= 1'b0;
      r_last0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (weight_ready_i && (BURST_SIZE != '0)) begin
            r_n     <= BURST_SIZE;
            r_cnt   <= (AW+1)'(1);
            r_en0   <= 1'b1;
            r_last0 <= (BURST_SIZE == (AW+1)'(1));
            r_addr0 <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt < r_n) begin
            r_en0   <= 1'b1;
            r_last0 <= (r_cnt == (r_n - (AW+1)'(1)));
            r_addr0 <= r_cnt[AW-1:0];
            r_cnt   <= r_cnt + (AW+1)'(1);
          end
          if (burst_last_o) r_state <= S_DONE;
        end
        S_DONE: begin
          if (!weight_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Skew chain: each lane sees the previous lane's enable/address/last one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_ch   <= '0;
      r_last_ch <= '0;
      for (int i = 1; i < BAND_WIDTH; i++) r_addr_ch[i] <= '0;
      r_rvld       <= '0;
      r_rlast      <= 1'b0;
      burst_last_o <= 1'b0;
    end else begin
      r_en_ch      <= {r_en_ch[BAND_WIDTH-2:1], r_en0};
      r_last_ch    <= {r_last_ch[BAND_WIDTH-2:1], r_last0};
      r_addr_ch[1] <= r_addr0;
      for (int i = 2; i < BAND_WIDTH; i++) r_addr_ch[i] <= r_addr_ch[i-1];
      r_rvld       <= w_en;
      r_rlast      <= w_en[BAND_WIDTH-1] & w_last[BAND_WIDTH-1];
      burst_last_o <= r_rlast;
    end
  end

  assign w_addr[0] = r_addr0;

  for (genvar b = 0; b < BAND_WIDTH; b++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_mem [SRAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    if (b > 0) begin : g_addr
      assign w_addr[b] = r_addr_ch[b];
    end

    // Bank index decode; out-of-range bank indices never match any lane.
    assign w_we[b] = wea && (addra[AW+BA-1:AW] == BA'(b));

    // Simple dual-port bank, read-first: a colliding read returns the old word.
    always_ff @(posedge clk) begin
      if (w_we[b]) r_mem[addra[AW-1:0]] <= dia;
      if (w_en[b]) r_rdata <= r_mem[w_addr[b]];
    end

    // Lane output register; data holds its last value while invalid.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_valid_o[b] <= 1'b0;
        sa_data_o[b]    <= '0;
      end else begin
        data_valid_o[b] <= r_rvld[b];
        if (r_rvld[b]) sa_data_o[b] <= r_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_input_top.sv
// Scoreboard bench for data_input_top: the stimulus pushes one expected entry
// per (lane, word, cycle) for every burst; a monitor on the falling edge pops
// and checks them against a behavioural memory model.
module tb_data_input_top;
  localparam int BW = 25;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        wea;
  logic [14:0] addra;
  logic [7:0]  dia;
  logic [10:0] BURST_SIZE;
  logic        weight_ready_i;
  logic        data_valid_o [BW];
  logic [7:0]  sa_data_o [BW];
  logic        burst_last_o;

  data_input_top dut (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dia(dia),
    .BURST_SIZE(BURST_SIZE), .weight_ready_i(weight_ready_i),
    .data_valid_o(data_valid_o), .sa_data_o(sa_data_o),
    .burst_last_o(burst_last_o)
  );

  typedef struct {
    int lane;
    int k;
    int cyc;
    bit last;
  } exp_t;

  exp_t      sbq[$];
  logic [7:0] mem_m [BW][DEPTH];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every lane output is either an expected word or must be idle.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_last;
    logic [7:0] expd;
    if (rst) begin
      exp_last = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        tests_run++; tests_failed++;
        $display("FAIL missed lane%0d word%0d: no output at cycle %0d", e.lane, e.k, e.cyc);
      end
      for (int i = 0; i < BW; i++) begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc && sbq[0].lane == i) begin
          e = sbq.pop_front();
          expd = mem_m[i][e.k];
          tests_run++;
          if (data_valid_o[i] !== 1'b1 || sa_data_o[i] !== expd) begin
            tests_failed++;
            $display("FAIL lane%0d word%0d cyc%0d: got valid=%0b data=%0d, want valid=1 data=%0d",
                     i, e.k, cyc, data_valid_o[i], sa_data_o[i], expd);
          end
          if (e.last) exp_last = 1'b1;
        end else if (data_valid_o[i] !== 1'b0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected lane%0d cyc%0d: got valid=%0b data=%0d, want valid=0",
                   i, cyc, data_valid_o[i], sa_data_o[i]);
        end
      end
      if (exp_last || burst_last_o !== 1'b0) begin
        tests_run++;
        if (burst_last_o !== exp_last) begin
          tests_failed++;
          $display("FAIL burst_last cyc%0d: got %0b, want %0b", cyc, burst_last_o, exp_last);
        end
      end
    end
  end

  task automatic wr_word(input int addr, input int d);
    @(negedge clk); #1;
    wea = 1'b1; addra = 15'(addr); dia = 8'(d);
    if (addr / DEPTH < BW) mem_m[addr / DEPTH][addr % DEPTH] = 8'(d);
  endtask

  task automatic wr_stop();
    @(negedge clk); #1;
    wea = 1'b0;
  endtask

  // Raise the request; the next rising edge is E0, lane i word k lands after edge E0+2+i+k.
  task automatic start_burst(input int n);
    exp_t e;
    int e0;
    @(negedge clk); #1;
    BURST_SIZE = 11'(n);
    weight_ready_i = 1'b1;
    e0 = cyc + 1;
    for (int t = 0; t < n + BW - 1; t++) begin
      for (int i = 0; i < BW; i++) begin
        if (t - i >= 0 && t - i < n) begin
          e.lane = i; e.k = t - i; e.cyc = e0 + 2 + t;
          e.last = (i == BW - 1) && (t - i == n - 1);
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic wait_done(input int bound);
    int t;
    t = 0;
    while (sbq.size() > 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    tests_run++;
    if (sbq.size() > 0) begin
      tests_failed++;
      $display("FAIL burst timeout: %0d entries left, want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic hold(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic release_req();
    @(negedge clk); #1;
    weight_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < BW; i++) begin
      tests_run++;
      if (data_valid_o[i] !== 1'b0 || sa_data_o[i] !== 8'd0 || burst_last_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s lane%0d: got valid=%0b data=%0d last=%0b, want all 0",
                 name, i, data_valid_o[i], sa_data_o[i], burst_last_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wea = 1'b0; addra = '0; dia = '0;
    BURST_SIZE = '0; weight_ready_i = 1'b0;
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    hold(3);
    #1 rst = 1'b1;

    // Fill every bank: word(b,a) = (a+1) mod 256.
    for (int idx = 0; idx < BW * DEPTH; idx++) wr_word(idx, (idx + 1) % 256);
    wr_stop();

    // Out-of-range bank write must not disturb any bank.
    wr_word(27 * DEPTH + 5, 8'hAA);
    wr_stop();

    // Zero-length request keeps everything quiet.
    @(negedge clk); #1;
    BURST_SIZE = '0; weight_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_all_zero("zero_len");
    end
    release_req();

    // Full-depth burst.
    start_burst(1024);
    wait_done(1024 + BW + 10);
    hold(10);
    release_req();

    // Back-to-back bursts with the request held high past the end.
    start_burst(784); wait_done(784 + BW + 10); hold(12); release_req();
    start_burst(196); wait_done(196 + BW + 10); hold(12); release_req();
    start_burst(100); wait_done(100 + BW + 10); hold(12); release_req();
    start_burst(25);  wait_done(25 + BW + 10);  hold(12); release_req();

    // Single-word burst, request held.
    start_burst(1);
    wait_done(1 + BW + 10);
    hold(40);
    release_req();

    // Writes during a burst to words not yet read show up at the output.
    start_burst(100);
    hold(5);
    wr_word(3 * DEPTH + 90, 8'h5A);
    wr_word(24 * DEPTH + 99, 8'h77);
    wr_stop();
    wait_done(100 + BW + 10);
    release_req();

    // Reset mid-burst clears outputs at once and keeps the memory.
    start_burst(1024);
    hold(60);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check_all_zero("mid_reset");
    sbq.delete();
    weight_ready_i = 1'b0;
    hold(3);
    #1 rst = 1'b1;
    start_burst(25);
    wait_done(25 + BW + 10);
    release_req();

    hold(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
